// File: rtl/cb_io_filter_bank.sv
// Multi-channel IO debounce bank: polarity invert, 2-FF sync, prescaled debounce,
// sticky edge flags and a registered interrupt, all on sys_clk.
module cb_io_filter_bank #(
    parameter int unsigned CH_NUM  = 40,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 16
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [CH_NUM-1:0]   orign_opt_i,
    input  logic [CH_NUM-1:0]   inv_i,
    input  logic [PRESC_W-1:0]  presc_div_i,
    input  logic [CNT_W-1:0]    filter_cnt_i,
    input  logic [CH_NUM-1:0]   rise_en_i,
    input  logic [CH_NUM-1:0]   fall_en_i,
    input  logic [CH_NUM-1:0]   evt_clr_i,
    output logic [CH_NUM-1:0]   filter_opt_o,
    output logic [CH_NUM-1:0]   rise_flag_o,
    output logic [CH_NUM-1:0]   fall_flag_o,
    output logic                irq_o,
    output logic                tick_o
);

    localparam int unsigned CW1 = CNT_W + 1;

    logic [PRESC_W-1:0] r_pcnt;
    logic [CH_NUM-1:0]  r_s1;
    logic [CH_NUM-1:0]  r_s2;
    logic [CH_NUM-1:0]  r_state;
    logic [CH_NUM-1:0]  r_rise;
    logic [CH_NUM-1:0]  r_fall;
    logic               r_irq;

    logic               w_tick;
    logic [CNT_W-1:0]   w_thr;
    logic [CH_NUM-1:0]  w_diff;
    logic [CH_NUM-1:0]  w_commit;
    logic [CH_NUM-1:0]  w_set_rise;
    logic [CH_NUM-1:0]  w_set_fall;

    // ">=" rather than "==" so a lowered presc_div_i ticks at once instead of wrapping
    always_comb begin
        w_tick = ~rst && (r_pcnt >= presc_div_i);
        w_thr  = (filter_cnt_i == '0) ? CNT_W'(1) : filter_cnt_i;
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W:0]   w_inc;

        assign w_inc       = {1'b0, r_cnt} + CW1'(1);
        assign w_diff[g]   = r_s2[g] ^ r_state[g];
        assign w_commit[g] = w_tick & w_diff[g] & (w_inc >= {1'b0, w_thr});

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (!w_diff[g] || w_commit[g]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_inc[CNT_W-1:0];
                end
            end
        end
    end

    assign w_set_rise = w_commit & r_s2;
    assign w_set_fall = w_commit & ~r_s2;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_state <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_s1    <= orign_opt_i ^ inv_i;
            r_s2    <= r_s1;
            r_pcnt  <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
            r_state <= r_state ^ w_commit;
            // a new edge outranks a clear arriving in the same cycle
            r_rise  <= w_set_rise | (r_rise & ~evt_clr_i);
            r_fall  <= w_set_fall | (r_fall & ~evt_clr_i);
            r_irq   <= |((r_rise & rise_en_i) | (r_fall & fall_en_i));
        end
    end

    assign filter_opt_o = r_state;
    assign rise_flag_o  = r_rise;
    assign fall_flag_o  = r_fall;
    assign irq_o        = r_irq;
    assign tick_o       = w_tick;

endmodule

// File: tb/tb_cb_io_filter_bank.sv
// Self-checking bench for cb_io_filter_bank: directed scenarios plus randomized
// traffic compared against a tick/run-length reference model.
module tb_cb_io_filter_bank;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [39:0] orign, inv, rise_en, fall_en, evt_clr;
    logic [15:0] presc;
    logic [7:0]  fcnt;
    logic [39:0] filt, rflag, fflag;
    logic        irq, tick;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [39:0] m_s1, m_s2, m_state, m_rise, m_fall;
    logic        m_irq;
    int          m_pcnt;
    int          run [40];

    cb_io_filter_bank #(.CH_NUM(40), .CNT_W(8), .PRESC_W(16)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .orign_opt_i  (orign),
        .inv_i        (inv),
        .presc_div_i  (presc),
        .filter_cnt_i (fcnt),
        .rise_en_i    (rise_en),
        .fall_en_i    (fall_en),
        .evt_clr_i    (evt_clr),
        .filter_opt_o (filt),
        .rise_flag_o  (rflag),
        .fall_flag_o  (fflag),
        .irq_o        (irq),
        .tick_o       (tick)
    );

    always #5 sys_clk = ~sys_clk;

    // Output commits once a channel has seen T consecutive sample ticks disagreeing with it.
    always @(posedge sys_clk) begin
        int          thr;
        logic        tk;
        logic [39:0] setr, setf;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_rise = '0; m_fall = '0;
            m_irq = 1'b0; m_pcnt = 0;
            for (int ch = 0; ch < 40; ch++) run[ch] = 0;
        end else begin
            tk    = (m_pcnt >= int'(presc));
            thr   = (fcnt == 8'd0) ? 1 : int'(fcnt);
            m_irq = |((m_rise & rise_en) | (m_fall & fall_en));
            setr  = '0;
            setf  = '0;
            if (tk) begin
                for (int ch = 0; ch < 40; ch++) begin
                    if (m_s2[ch] != m_state[ch]) begin
                        run[ch] = run[ch] + 1;
                        if (run[ch] >= thr) begin
                            m_state[ch] = m_s2[ch];
                            run[ch] = 0;
                            if (m_s2[ch]) setr[ch] = 1'b1;
                            else          setf[ch] = 1'b1;
                        end
                    end else begin
                        run[ch] = 0;
                    end
                end
            end
            m_rise = setr | (m_rise & ~evt_clr);
            m_fall = setf | (m_fall & ~evt_clr);
            m_pcnt = tk ? 0 : m_pcnt + 1;
            m_s2   = m_s1;
            m_s1   = orign ^ inv;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
        end
    endtask

    task automatic clear_flags();
        evt_clr = '1;
        step(1);
        evt_clr = '0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        orign = 40'({$urandom(), $urandom()});
        inv   = 40'({$urandom(), $urandom()});
        step(2);
        checks++; if (filt !== 40'd0)  begin errors++; $display("FAIL reset_filter got=%h exp=0", filt); end
        checks++; if (rflag !== 40'd0) begin errors++; $display("FAIL reset_rise got=%h exp=0", rflag); end
        checks++; if (fflag !== 40'd0) begin errors++; $display("FAIL reset_fall got=%h exp=0", fflag); end
        checks++; if (irq !== 1'b0)    begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (tick !== 1'b0)   begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        orign = '0;
        inv   = '0;
        rst   = 1'b0;
        step(4);
    endtask

    task automatic test_basic();
        presc = 16'd0;
        fcnt  = 8'd4;
        rise_en = '0;
        rise_en[0] = 1'b1;
        orign[0] = 1'b1;
        step(5);
        checks++; if (filt[0] !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", filt[0]); end
        step(1);
        checks++; if (filt[0] !== 1'b1)  begin errors++; $display("FAIL basic_rise got=%b exp=1", filt[0]); end
        checks++; if (rflag[0] !== 1'b1) begin errors++; $display("FAIL basic_rflag got=%b exp=1", rflag[0]); end
        checks++; if (irq !== 1'b0)      begin errors++; $display("FAIL basic_irq_early got=%b exp=0", irq); end
        step(1);
        checks++; if (irq !== 1'b1)      begin errors++; $display("FAIL basic_irq got=%b exp=1", irq); end
        orign[0] = 1'b0;
        step(8);
        checks++; if (filt !== m_state) begin errors++; $display("FAIL basic_model got=%h exp=%h", filt, m_state); end
        rise_en = '0;
        clear_flags();
    endtask

    task automatic test_glitch();
        fcnt = 8'd4;
        orign[3] = 1'b1;
        step(3);
        orign[3] = 1'b0;
        step(10);
        checks++; if (filt[3] !== 1'b0)  begin errors++; $display("FAIL glitch_filter got=%b exp=0", filt[3]); end
        checks++; if (rflag[3] !== 1'b0 || fflag[3] !== 1'b0) begin
            errors++; $display("FAIL glitch_flags got=%b%b exp=00", rflag[3], fflag[3]);
        end
        orign[3] = 1'b1;
        step(4);
        orign[3] = 1'b0;
        step(3);
        checks++; if (filt[3] !== 1'b1 || rflag[3] !== 1'b1) begin
            errors++; $display("FAIL glitch_accept got=%b/%b exp=1/1", filt[3], rflag[3]);
        end
        step(6);
        checks++; if (filt[3] !== 1'b0 || fflag[3] !== 1'b1) begin
            errors++; $display("FAIL glitch_fall got=%b/%b exp=0/1", filt[3], fflag[3]);
        end
        clear_flags();
    endtask

    task automatic test_prescaler();
        int last, nt, waited;
        bit exp_t;
        presc = 16'd9;
        fcnt  = 8'd3;
        last = -1;
        nt = 0;
        for (int c = 0; c < 60; c++) begin
            step(1);
            exp_t = (m_pcnt >= 9);
            checks++; if (tick !== exp_t) begin errors++; $display("FAIL presc_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (c - last != 10) begin errors++; $display("FAIL presc_period got=%0d exp=10", c - last); end
                end
                last = c;
                nt++;
            end
        end
        checks++; if (nt != 6) begin errors++; $display("FAIL presc_count got=%0d exp=6", nt); end
        waited = 0;
        while (tick !== 1'b1 && waited < 20) begin step(1); waited++; end
        orign[12] = 1'b1;
        waited = 0;
        while (filt[12] !== 1'b1 && waited < 60) begin step(1); waited++; end
        checks++; if (waited != 31) begin errors++; $display("FAIL presc_latency got=%0d exp=31", waited); end
        waited = 0;
        while (m_pcnt != 5 && waited < 20) begin step(1); waited++; end
        checks++; if (m_pcnt != 5) begin errors++; $display("FAIL presc_wait got=%0d exp=5", m_pcnt); end
        presc = 16'd2;
        #1;
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL presc_lower got=%b exp=1", tick); end
        step(1);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL presc_after got=%b exp=0", tick); end
        presc = 16'd0;
        orign[12] = 1'b0;
        step(6);
        clear_flags();
    endtask

    task automatic test_threshold();
        presc = 16'd0;
        fcnt  = 8'd0;
        orign[5] = 1'b1;
        step(2);
        checks++; if (filt[5] !== 1'b0) begin errors++; $display("FAIL thr0_early got=%b exp=0", filt[5]); end
        step(1);
        checks++; if (filt[5] !== 1'b1) begin errors++; $display("FAIL thr0_rise got=%b exp=1", filt[5]); end
        fcnt = 8'd200;
        orign[9] = 1'b1;
        step(52);
        checks++; if (filt[9] !== 1'b0) begin errors++; $display("FAIL thr_hold got=%b exp=0", filt[9]); end
        fcnt = 8'd5;
        step(1);
        checks++; if (filt[9] !== 1'b1) begin errors++; $display("FAIL thr_lower got=%b exp=1", filt[9]); end
        clear_flags();
    endtask

    task automatic test_flags();
        rise_en = '0;
        fall_en = '0;
        fcnt = 8'd1;
        clear_flags();
        orign[9] = 1'b0;
        step(3);
        checks++; if (fflag[9] !== 1'b1) begin errors++; $display("FAIL flag_fall got=%b exp=1", fflag[9]); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flag_irq_masked got=%b exp=0", irq); end
        fall_en[9] = 1'b1;
        step(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL flag_irq_en got=%b exp=1", irq); end
        orign[9] = 1'b1;
        step(2);
        evt_clr[9] = 1'b1;
        step(1);
        evt_clr[9] = 1'b0;
        checks++; if (rflag[9] !== 1'b1 || fflag[9] !== 1'b0) begin
            errors++; $display("FAIL flag_set_wins got=%b/%b exp=1/0", rflag[9], fflag[9]);
        end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flag_irq_after_clr got=%b exp=0", irq); end
        rise_en[9] = 1'b1;
        step(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL flag_irq_rise got=%b exp=1", irq); end
        evt_clr[9] = 1'b1;
        step(1);
        evt_clr[9] = 1'b0;
        checks++; if (rflag[9] !== 1'b0) begin errors++; $display("FAIL flag_clear got=%b exp=0", rflag[9]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL flag_irq_lag got=%b exp=1", irq); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flag_irq_drop got=%b exp=0", irq); end
        rise_en = '0;
        fall_en = '0;
    endtask

    task automatic test_polarity_reset();
        rst = 1'b1;
        orign = '0;
        inv = '0;
        inv[7] = 1'b1;
        fcnt = 8'd4;
        presc = 16'd0;
        step(1);
        checks++; if (filt !== 40'd0) begin errors++; $display("FAIL pol_reset got=%h exp=0", filt); end
        rst = 1'b0;
        step(5);
        checks++; if (filt[7] !== 1'b0) begin errors++; $display("FAIL pol_early got=%b exp=0", filt[7]); end
        step(1);
        checks++; if (filt[7] !== 1'b1 || rflag[7] !== 1'b1) begin
            errors++; $display("FAIL pol_rise got=%b/%b exp=1/1", filt[7], rflag[7]);
        end
        inv[7] = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        checks++; if ({filt, rflag, fflag, irq, tick} !== 121'd0) begin
            errors++; $display("FAIL midreset got=%h/%h/%h/%b/%b exp=0", filt, rflag, fflag, irq, tick);
        end
        rst = 1'b0;
        step(10);
        checks++; if ({filt, rflag, fflag} !== 120'd0) begin
            errors++; $display("FAIL post_reset got=%h/%h/%h exp=0", filt, rflag, fflag);
        end
    endtask

    task automatic test_random();
        bit exp_t;
        for (int seg = 0; seg < 6; seg++) begin
            presc   = 16'($urandom_range(2));
            fcnt    = 8'($urandom_range(5));
            rise_en = 40'({$urandom(), $urandom()});
            fall_en = 40'({$urandom(), $urandom()});
            for (int c = 0; c < 250; c++) begin
                for (int ch = 0; ch < 40; ch++) begin
                    if ($urandom_range(7) == 0) orign[ch] = ~orign[ch];
                    evt_clr[ch] = ($urandom_range(15) == 0);
                end
                if ($urandom_range(63) == 0) inv[$urandom_range(39)] ^= 1'b1;
                step(1);
                exp_t = (m_pcnt >= int'(presc));
                checks++; if (filt !== m_state) begin errors++; $display("FAIL rnd_filter got=%h exp=%h", filt, m_state); end
                checks++; if (rflag !== m_rise) begin errors++; $display("FAIL rnd_rise got=%h exp=%h", rflag, m_rise); end
                checks++; if (fflag !== m_fall) begin errors++; $display("FAIL rnd_fall got=%h exp=%h", fflag, m_fall); end
                checks++; if (irq !== m_irq)    begin errors++; $display("FAIL rnd_irq got=%b exp=%b", irq, m_irq); end
                checks++; if (tick !== exp_t)   begin errors++; $display("FAIL rnd_tick got=%b exp=%b", tick, exp_t); end
            end
        end
        evt_clr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        orign = '0; inv = '0; rise_en = '0; fall_en = '0; evt_clr = '0;
        presc = 16'd0;
        fcnt  = 8'd4;
        @(negedge sys_clk);
        test_reset();
        test_basic();
        test_glitch();
        test_prescaler();
        test_threshold();
        test_flags();
        test_polarity_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cb_io_filter_bank.md
# cb_io_filter_bank

Multi-channel IO debounce filter with programmable debounce depth and sample rate, polarity control and edge-event capture. It replaces a fixed-count, two-clock per-bit filter array with one single-clock bank. The input synchroniser, sample-rate prescaler and interrupt generation are built in. It sits between raw photoelectric/IO pins and the Nios II register interface, which supplies configuration and reads filtered levels and sticky edge flags.

## Interface
- CH_NUM, 40, number of filtered channels
- CNT_W, 8, width of debounce counter and threshold
- PRESC_W, 16, width of sample-rate prescaler

- sys_clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- orign_opt_i  in  CH_NUM  raw asynchronous IO inputs
- inv_i  in  CH_NUM  per-channel polarity invert (1 = invert before filtering)
- presc_div_i  in  PRESC_W  sample tick every presc_div_i+1 sys_clk cycles
- filter_cnt_i  in  CNT_W  debounce threshold in ticks; 0 treated as 1
- rise_en_i  in  CH_NUM  rising-edge interrupt enable
- fall_en_i  in  CH_NUM  falling-edge interrupt enable
- evt_clr_i  in  CH_NUM  one-cycle write-1-to-clear for both edge flags of a channel
- filter_opt_o  out  CH_NUM  debounced level
- rise_flag_o  out  CH_NUM  sticky rising-edge flag
- fall_flag_o  out  CH_NUM  sticky falling-edge flag
- irq_o  out  1  registered OR of enabled flags
- tick_o  out  1  one-cycle sample strobe (debug)

## Operation
- Per channel: x = orign_opt_i ^ inv_i → 2-FF synchroniser (s1, s2) → debounce counter cnt[CNT_W] → state register (= filter_opt_o).
- Prescaler: pcnt counts 0..presc_div_i. tick = (pcnt >= presc_div_i); on tick pcnt←0, else pcnt←pcnt+1. presc_div_i=0 gives a tick every cycle. Lowering presc_div_i below pcnt forces a tick on the next cycle, with no wrap through 2^PRESC_W.
- Effective threshold T = (filter_cnt_i==0) ? 1 : filter_cnt_i, sampled live each tick.
- On tick, per channel:
  - s2 == state: cnt←0.
  - s2 != state and cnt+1 >= T: state←s2, cnt←0, set rise_flag (s2=1) or fall_flag (s2=0).
  - otherwise: cnt←cnt+1.
- No tick: cnt and state hold.
- The ">=" compare means lowering filter_cnt_i mid-count commits on the next tick. cnt never exceeds T−1, so it cannot overflow.
- A glitch shorter than T consecutive differing ticks resets cnt and produces no output change.
- Flags: set by a state change; cleared by evt_clr_i[n]. Set and clear in the same cycle: set wins.
- irq_o ← |((rise_flag & rise_en_i) | (fall_flag & fall_en_i)), registered.
- Changing inv_i feeds the synchroniser and is filtered like any input change, so it raises a flag only after T ticks.

## Timing
- Reset (synchronous, 1 cycle): s1, s2, cnt, state, pcnt, flags, irq_o, tick_o = 0. filter_opt_o = 0 regardless of inv_i. Reset mid-count discards progress and generates no events. A channel with x=1 at reset release rises after 2+T ticks and sets rise_flag.
- Latency, presc_div_i=0: x sampled into s1 at edge E, s2 at E+1. filter_opt_o and flag change at edge E+1+T. irq_o follows at E+2+T.
- Latency, general: filter_opt_o updates on the T-th tick at or after edge E+2 while s2 is continuously different.
- tick_o is high in the cycle in which tick is evaluated true.
- Flag clear takes effect the next edge. irq_o deasserts one cycle after that.

## Test plan
- Basic debounce: presc=0, T=4, ch0 0→1 held → filter_opt_o[0] rises at E+5, rise_flag_o[0]=1; with rise_en_i[0]=1, irq_o=1 at E+6.
- Glitch reject: presc=0, T=4, ch3 pulses high 3 cycles → filter_opt_o[3] stays 0, no flags. Pulse of 4 cycles at s2 → accepted.
- Prescaler: presc=9, T=3 → tick_o every 10 cycles. Output changes on the 3rd tick after s2 changes (20–30 cycles after input). presc lowered from 9 to 2 while pcnt=5 → tick on the next cycle.
- Threshold edge cases: filter_cnt_i=0 behaves as 1. Lowering T from 200 to 5 while cnt=50 commits on the next tick.
- Flags/irq: fall with fall_en=0 → fall_flag=1, irq_o=0. Set fall_en=1 → irq_o=1 next cycle. evt_clr in the same cycle as a new edge → flag stays 1. Clear alone → flag 0, irq_o 0 one cycle later.
- Polarity/reset: inv_i[7]=1 with pin low → ch7 rises after 2+T ticks. Assert rst mid-count → all outputs 0 next edge, no spurious flags after release.
